// File: rtl/spi_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller_if
// Description : Command/response handshake bundle between a host and the
//               SPI register controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_controller_if #(
  parameter int ADDR_W = 4,
  parameter int REG_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr_rdn;
  logic [ADDR_W-1:0] cmd_addr;
  logic [REG_W-1:0]  cmd_wdata;
  logic              rsp_valid;
  logic [REG_W-1:0]  rsp_rdata;

  // Host side: issues commands, receives responses
  modport master (
    output cmd_valid,
    output cmd_wr_rdn,
    output cmd_addr,
    output cmd_wdata,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  // Controller side
  modport slave (
    input  cmd_valid,
    input  cmd_wr_rdn,
    input  cmd_addr,
    input  cmd_wdata,
    output cmd_ready,
    output rsp_valid,
    output rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller
// Description : SPI initiator for the on-chip SPI register peripheral. One
//               command -> one CS frame of {wr_rdn, addr, data}, MSB first,
//               all four CPOL/CPHA modes, programmable SCLK half-period.
// Options     : SPI_CTRL_LOOPBACK_EN - adds a 'loopback' input that routes
//               spi_mosi into the read sampler instead of spi_miso.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_controller #(
  parameter int ADDR_W = 4,
  parameter int REG_W  = 8,
  parameter int DIV_W  = 8
) (
  input  wire logic             clk,
  input  wire logic             rstb,
  input  wire logic             ena,
  input  wire logic [1:0]       mode,
  input  wire logic [DIV_W-1:0] clk_div,
  spi_controller_if.slave       bus,
  output logic                  busy,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  wire logic             spi_miso
`ifdef SPI_CTRL_LOOPBACK_EN
  ,
  input  wire logic             loopback
`endif
);

  localparam int N      = 1 + ADDR_W + REG_W;
  localparam int EDGE_W = $clog2(2 * N + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * N - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               wr_q, wr_d;
  logic [N-1:0]       tx_q, tx_d;
  logic [REG_W-1:0]   rx_q, rx_d;
  logic [EDGE_W-1:0]  edge_q, edge_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [REG_W-1:0]   rdata_q, rdata_d;

  logic [N-1:0]       w_frame;
  logic               w_expire;
  logic               w_lead;
  logic               w_sample;
  logic               w_miso;

  assign w_frame  = {bus.cmd_wr_rdn, bus.cmd_addr, bus.cmd_wdata};
  // Half-period ends on the cycle the down-counter reaches zero
  assign w_expire = (cnt_q == '0);
  // Edge number edge_q+1 is odd (leading) when edge_q is even
  assign w_lead   = ~edge_q[0];
  // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
  assign w_sample = (w_lead != cpha_q);

`ifdef SPI_CTRL_LOOPBACK_EN
  assign w_miso = loopback ? mosi_q : spi_miso;
`else
  assign w_miso = spi_miso;
`endif

  assign bus.cmd_ready = ena & (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign spi_cs_n      = cs_n_q;
  assign spi_clk       = sclk_q;
  assign spi_mosi      = mosi_q;

  // Next-state, timing and serial datapath; ena=0 leaves every register held
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    wr_d        = wr_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    edge_d      = edge_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;

    if (ena) begin
      rsp_valid_d = 1'b0;
      if (state_q != ST_IDLE) begin
        cnt_d = w_expire ? div_q : cnt_q - 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            state_d = ST_SETUP;
            cnt_d   = clk_div;
            div_d   = clk_div;
            cpol_d  = mode[1];
            cpha_d  = mode[0];
            wr_d    = bus.cmd_wr_rdn;
            cs_n_d  = 1'b0;
            sclk_d  = mode[1];
            edge_d  = '0;
            // wr_rdn goes out during SETUP; for CPHA=1 the first leading
            // edge re-presents it, so the shifter keeps it at the top
            mosi_d  = w_frame[N-1];
            tx_d    = mode[0] ? w_frame : {w_frame[N-2:0], 1'b0};
          end
        end

        ST_SETUP: begin
          if (w_expire) begin
            state_d = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_expire) begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + 1'b1;
            if (w_sample) begin
              rx_d = {rx_q[REG_W-2:0], w_miso};
            end else if (edge_q != LAST_EDGE) begin
              mosi_d = tx_q[N-1];
              tx_d   = {tx_q[N-2:0], 1'b0};
            end
            if (edge_q == LAST_EDGE) begin
              state_d = ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (w_expire) begin
            state_d     = ST_GAP;
            cs_n_d      = 1'b1;
            mosi_d      = 1'b0;
            rsp_valid_d = 1'b1;
            if (!wr_q) begin
              rdata_d = rx_q;
            end
          end
        end

        ST_GAP: begin
          if (w_expire) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      wr_q        <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      edge_q      <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      wr_q        <= wr_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      edge_q      <= edge_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_controller
// Description : Directed self-checking bench for spi_controller with a small
//               behavioural SPI register peripheral model.
// Options     : SPI_CTRL_LOOPBACK_EN - also runs the loopback read in all modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

  logic       clk;
  logic       rstb;
  logic       ena;
  logic [1:0] mode;
  logic [7:0] clk_div;
  logic       busy;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;
`ifdef SPI_CTRL_LOOPBACK_EN
  logic       loopback;
`endif

  spi_controller_if #(.ADDR_W(4), .REG_W(8)) bus ();

  spi_controller #(.ADDR_W(4), .REG_W(8), .DIV_W(8)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .mode     (mode),
    .clk_div  (clk_div),
    .bus      (bus),
    .busy     (busy),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
`ifdef SPI_CTRL_LOOPBACK_EN
    ,
    .loopback (loopback)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Single comparison point for the whole bench
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Peripheral register contents seen by the model
  function automatic logic [7:0] reg_model(input logic [3:0] a);
    case (a)
      4'h3:    return 8'hFF;
      4'h5:    return 8'hC3;
      4'h9:    return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  // Monitor and peripheral model state
  logic        m_cpol = 1'b0;
  logic        m_cpha = 1'b0;
  logic        prev_cs_n = 1'b1;
  logic        prev_sclk = 1'b0;
  int          rsp_cnt = 0;
  int          edge_cnt = 0;
  int          rise_cnt = 0;
  int          bad_sp = 0;
  int          last_edge_cyc = -1;
  int          cyc = 0;
  int          cs_high_run = 0;
  int          gap_len = 0;
  int          pm_samples = 0;
  logic [12:0] pm_rx = '0;
  logic [7:0]  pm_rd = '0;
  int          exp_h = 2;

  // Sample bus and SPI pins away from the active edge; also acts as peripheral
  always @(negedge clk) begin
    cyc++;
    if (bus.rsp_valid) rsp_cnt++;
    if (!spi_cs_n && prev_cs_n) begin
      gap_len       = cs_high_run;
      edge_cnt      = 0;
      rise_cnt      = 0;
      bad_sp        = 0;
      last_edge_cyc = -1;
      pm_samples    = 0;
      pm_rx         = '0;
      spi_miso      = 1'b0;
    end
    if (spi_cs_n) cs_high_run++;
    else          cs_high_run = 0;
    if (!spi_cs_n && !prev_cs_n && (spi_clk != prev_sclk)) begin
      edge_cnt++;
      if (spi_clk) rise_cnt++;
      if (last_edge_cyc >= 0 && (cyc - last_edge_cyc) != exp_h) bad_sp++;
      last_edge_cyc = cyc;
      if ((spi_clk != m_cpol) != m_cpha) begin
        pm_rx = {pm_rx[11:0], spi_mosi};
        pm_samples++;
        if (pm_samples == 5) pm_rd = reg_model(pm_rx[3:0]);
      end else if (pm_samples >= 5 && pm_samples < 13) begin
        spi_miso = pm_rd[12-pm_samples];
      end
    end
    prev_cs_n = spi_cs_n;
    prev_sclk = spi_clk;
  end

  task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [7:0] d,
                          input logic [1:0] m, input logic [7:0] dv);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_wr_rdn = wr;
    bus.cmd_addr   = a;
    bus.cmd_wdata  = d;
    mode           = m;
    clk_div        = dv;
    while (!bus.cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) check_eq("accept_timeout", {31'd0, bus.cmd_ready}, 32'd1);
    m_cpol = m[1];
    m_cpha = m[0];
    exp_h  = int'(dv) + 1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input string tag);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (rsp_cnt < target) check_eq({tag, "_timeout"}, rsp_cnt, target);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    int n;
    int hold_bad;
    logic [2:0] snap;

    rstb           = 1'b1;
    ena            = 1'b1;
    mode           = 2'b00;
    clk_div        = 8'd1;
    spi_miso       = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_wr_rdn = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
`ifdef SPI_CTRL_LOOPBACK_EN
    loopback       = 1'b0;
`endif
    #2 rstb = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_cs_n",      {31'd0, spi_cs_n},      32'd1);
    check_eq("rst_sclk",      {31'd0, spi_clk},       32'd0);
    check_eq("rst_mosi",      {31'd0, spi_mosi},      32'd0);
    check_eq("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_eq("rst_rdata",     {24'd0, bus.rsp_rdata}, 32'd0);
    check_eq("rst_busy",      {31'd0, busy},          32'd0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0 write addr 3 data A5, clk_div 1; mode/div changes afterwards ignored
    base = rsp_cnt;
    send_cmd(1'b1, 4'h3, 8'hA5, 2'b00, 8'd1);
    mode    = 2'b11;
    clk_div = 8'd7;
    @(negedge clk);
    check_eq("wr_busy",      {31'd0, busy},          32'd1);
    check_eq("wr_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    wait_rsp(base + 1, "wr");
    check_eq("wr_mosi_frame", {19'd0, pm_rx}, 32'h13A5);
    check_eq("wr_pulses",     rise_cnt,       32'd13);
    check_eq("wr_spacing",    bad_sp,         32'd0);
    repeat (10) @(negedge clk);
    check_eq("wr_rsp_count",  rsp_cnt - base, 32'd1);
    check_eq("wr_rdata_kept", {24'd0, bus.rsp_rdata}, 32'd0);

    // Mode 3 read addr 9 -> 3C, SCLK idles high
    base = rsp_cnt;
    send_cmd(1'b0, 4'h9, 8'h00, 2'b11, 8'd1);
    wait_rsp(base + 1, "rd3");
    check_eq("rd3_rdata",    {24'd0, bus.rsp_rdata}, 32'h3C);
    check_eq("rd3_hdr",      {27'd0, pm_rx[12:8]},   32'h09);
    check_eq("rd3_spacing",  bad_sp,                 32'd0);
    repeat (5) @(negedge clk);
    check_eq("rd3_sclk_idle", {31'd0, spi_clk},      32'd1);

    // Back-to-back write then read, clk_div 2
    base = rsp_cnt;
    send_cmd(1'b1, 4'h3, 8'h0F, 2'b00, 8'd2);
    send_cmd(1'b0, 4'h5, 8'h00, 2'b00, 8'd2);
    @(negedge clk);
    check_eq("b2b_cs_gap_ge3", {31'd0, (gap_len >= 3)}, 32'd1);
    wait_rsp(base + 2, "b2b");
    repeat (10) @(negedge clk);
    check_eq("b2b_rsp_count", rsp_cnt - base,         32'd2);
    check_eq("b2b_rdata",     {24'd0, bus.rsp_rdata}, 32'hC3);

    // Reset after the 5th SCLK edge of a mode 0 frame
    base = rsp_cnt;
    send_cmd(1'b0, 4'h9, 8'h00, 2'b00, 8'd1);
    n = 0;
    while (edge_cnt < 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("rstmid_reached_edge5", {31'd0, (edge_cnt >= 5)}, 32'd1);
    rstb = 1'b0;
    #1;
    check_eq("rstmid_cs_n", {31'd0, spi_cs_n}, 32'd1);
    check_eq("rstmid_sclk", {31'd0, spi_clk},  32'd0);
    check_eq("rstmid_mosi", {31'd0, spi_mosi}, 32'd0);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("rstmid_no_rsp", rsp_cnt - base, 32'd0);
    send_cmd(1'b0, 4'h9, 8'h00, 2'b00, 8'd1);
    wait_rsp(base + 1, "rstmid_next");
    check_eq("rstmid_next_rdata", {24'd0, bus.rsp_rdata}, 32'h3C);

    // ena low mid-frame freezes pins, frame still completes correctly (mode 2)
    base = rsp_cnt;
    send_cmd(1'b0, 4'h5, 8'h00, 2'b10, 8'd1);
    n = 0;
    while (edge_cnt < 7 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ena = 1'b0;
    @(negedge clk);
    snap = {spi_cs_n, spi_clk, spi_mosi};
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({spi_cs_n, spi_clk, spi_mosi} != snap || bus.cmd_ready) hold_bad++;
    end
    check_eq("ena_hold", hold_bad, 32'd0);
    ena = 1'b1;
    wait_rsp(base + 1, "ena");
    check_eq("ena_rdata", {24'd0, bus.rsp_rdata}, 32'hC3);

    // clk_div = 0 (H = 1), mode 1 read
    base = rsp_cnt;
    send_cmd(1'b0, 4'h9, 8'h00, 2'b01, 8'd0);
    wait_rsp(base + 1, "div0");
    check_eq("div0_rdata",   {24'd0, bus.rsp_rdata}, 32'h3C);
    check_eq("div0_spacing", bad_sp,                 32'd0);

`ifdef SPI_CTRL_LOOPBACK_EN
    loopback = 1'b1;
    for (int m = 0; m < 4; m++) begin
      base = rsp_cnt;
      send_cmd(1'b0, 4'h0, 8'h5A, m[1:0], 8'd1);
      wait_rsp(base + 1, "loop");
      check_eq($sformatf("loop_mode%0d", m), {24'd0, bus.rsp_rdata}, 32'h5A);
    end
    loopback = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
